// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int NUM_REQ        = 2;
  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_TIMEOUT    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [NUM_REQ-1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin pick: the requester not granted last wins a tie.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last,
  output logic [NUM_REQ-1:0] grant
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving two requesters one outstanding memory transfer at a time.
// Optional GRANT watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic [1:0]            s_valid,
  input  logic [1:0]            s_wr_rd,
  input  logic [ADDR_WIDTH-1:0] s0_addr,
  input  logic [ADDR_WIDTH-1:0] s1_addr,
  input  logic [DATA_WIDTH-1:0] s0_wdata,
  input  logic [DATA_WIDTH-1:0] s1_wdata,
  output logic [1:0]            s_ready,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic                  m_valid,
  output logic                  m_wr_rd,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic                  m_ready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  output logic                  err
);

  state_t                state;
  logic                  last;
  logic                  winner;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [NUM_REQ-1:0]    grant;
  logic                  timeout_hit;

  // A requester being acknowledged this cycle still shows s_valid; mask it so
  // the IDLE cycle after completion cannot re-grant the finished request.
  mem_arb_rr u_rr (
    .req   (s_valid & ~s_ready),
    .last  (last),
    .grant (grant)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state   <= IDLE;
      last    <= 1'b1;
      winner  <= 1'b0;
      rdata_q <= '0;
      s_ready <= '0;
      s_rdata <= '0;
      m_valid <= 1'b0;
      m_wr_rd <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else begin
      s_ready <= '0;
      case (state)
        IDLE: begin
          if (|grant) begin
            winner  <= grant[1];
            m_wr_rd <= grant[1] ? s_wr_rd[1] : s_wr_rd[0];
            m_addr  <= grant[1] ? s1_addr    : s0_addr;
            m_wdata <= grant[1] ? s1_wdata   : s0_wdata;
            m_valid <= 1'b1;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (m_ready) begin
            if (!m_wr_rd) rdata_q <= m_rdata;
            m_valid <= 1'b0;
            state   <= DONE;
          end else if (timeout_hit) begin
            m_valid <= 1'b0;
            s_ready <= req_onehot(winner);
            last    <= winner;
            state   <= IDLE;
          end
        end
        DONE: begin
          s_ready <= req_onehot(winner);
          if (!m_wr_rd) s_rdata <= rdata_q;
          last    <= winner;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;

  assign timeout_hit = (state == GRANT) && !m_ready && (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err <= timeout_hit;
      if (state == GRANT) wait_cnt <= wait_cnt + CW'(1);
      else                wait_cnt <= '0;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;

  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, write, read-back, back-pressure, contention, reset mid-transfer, timeout.
module tb_mem_arbiter;

  localparam int AW = 6;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          res;
  logic [1:0]    s_valid;
  logic [1:0]    s_wr_rd;
  logic [AW-1:0] s0_addr;
  logic [AW-1:0] s1_addr;
  logic [DW-1:0] s0_wdata;
  logic [DW-1:0] s1_wdata;
  logic [1:0]    s_ready;
  logic [DW-1:0] s_rdata;
  logic          m_valid;
  logic          m_wr_rd;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_ready;
  logic [DW-1:0] m_rdata;
  logic          err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(16)) dut (
    .clk      (clk),
    .res      (res),
    .s_valid  (s_valid),
    .s_wr_rd  (s_wr_rd),
    .s0_addr  (s0_addr),
    .s1_addr  (s1_addr),
    .s0_wdata (s0_wdata),
    .s1_wdata (s1_wdata),
    .s_ready  (s_ready),
    .s_rdata  (s_rdata),
    .m_valid  (m_valid),
    .m_wr_rd  (m_wr_rd),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_ready  (m_ready),
    .m_rdata  (m_rdata),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    s_valid  = 2'b00;
    s_wr_rd  = 2'b00;
    s0_addr  = '0;
    s1_addr  = '0;
    s0_wdata = '0;
    s1_wdata = '0;
    m_ready  = 1'b0;
    m_rdata  = '0;
  endtask

  task automatic apply_reset();
    res = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    res = 1'b0;
  endtask

  task automatic test_reset();
    res = 1'b1;
    idle_inputs();
    @(negedge clk);
    total_cnt++;
    if ({m_valid, m_wr_rd} !== 2'b00) $display("FAIL reset_mctl: got %b want 00", {m_valid, m_wr_rd});
    else pass_cnt++;
    total_cnt++;
    if ({m_addr, m_wdata} !== '0) $display("FAIL reset_mbus: got %h want 0", {m_addr, m_wdata});
    else pass_cnt++;
    total_cnt++;
    if ({s_ready, err} !== 3'b000) $display("FAIL reset_strobes: got %b want 000", {s_ready, err});
    else pass_cnt++;
    total_cnt++;
    if (s_rdata !== 16'h0000) $display("FAIL reset_rdata: got %h want 0000", s_rdata);
    else pass_cnt++;
    res = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (m_valid !== 1'b0) $display("FAIL idle_no_req: got m_valid=%b want 0", m_valid);
    else pass_cnt++;
  endtask

  task automatic test_write();
    s_valid = 2'b01; s_wr_rd = 2'b01; s0_addr = 6'd5; s0_wdata = 16'hA5A5; m_ready = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({m_valid, m_wr_rd, m_addr, m_wdata, s_ready} !== {1'b1, 1'b1, 6'd5, 16'hA5A5, 2'b00})
      $display("FAIL wr_grant: got v=%b w=%b a=%0d d=%h r=%b want v=1 w=1 a=5 d=a5a5 r=00",
               m_valid, m_wr_rd, m_addr, m_wdata, s_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({m_valid, s_ready} !== 3'b000) $display("FAIL wr_done: got v=%b r=%b want v=0 r=00", m_valid, s_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (s_ready !== 2'b01) $display("FAIL wr_ready: got %b want 01", s_ready);
    else pass_cnt++;
    s_valid = 2'b00;
    @(negedge clk);
    total_cnt++;
    if ({m_valid, s_ready} !== 3'b000) $display("FAIL wr_pulse_width: got v=%b r=%b want v=0 r=00", m_valid, s_ready);
    else pass_cnt++;
    total_cnt++;
    if (s_rdata !== 16'h0000) $display("FAIL wr_no_rdata: got %h want 0000", s_rdata);
    else pass_cnt++;
  endtask

  task automatic test_read();
    idle_inputs();
    s_valid = 2'b10; s_wr_rd = 2'b00; s1_addr = 6'd5; m_rdata = 16'hA5A5; m_ready = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({m_valid, m_wr_rd, m_addr} !== {1'b1, 1'b0, 6'd5})
      $display("FAIL rd_grant: got v=%b w=%b a=%0d want v=1 w=0 a=5", m_valid, m_wr_rd, m_addr);
    else pass_cnt++;
    @(negedge clk);
    m_rdata = 16'hDEAD;
    @(negedge clk);
    total_cnt++;
    if (s_ready !== 2'b10) $display("FAIL rd_ready: got %b want 10", s_ready);
    else pass_cnt++;
    total_cnt++;
    if (s_rdata !== 16'hA5A5) $display("FAIL rd_data: got %h want a5a5", s_rdata);
    else pass_cnt++;
    s_valid = 2'b00;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (s_rdata !== 16'hA5A5) $display("FAIL rd_hold: got %h want a5a5", s_rdata);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    idle_inputs();
    s_valid = 2'b01; s_wr_rd = 2'b01; s0_addr = 6'd9; s0_wdata = 16'h1234;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if ({m_valid, m_addr, m_wdata, s_ready, err} !== {1'b1, 6'd9, 16'h1234, 2'b00, 1'b0})
        $display("FAIL bp_stable_%0d: got v=%b a=%0d d=%h r=%b e=%b want v=1 a=9 d=1234 r=00 e=0",
                 i, m_valid, m_addr, m_wdata, s_ready, err);
      else pass_cnt++;
      if (i == 4) m_ready = 1'b1;
      @(negedge clk);
    end
    total_cnt++;
    if ({m_valid, s_ready} !== 3'b000) $display("FAIL bp_done: got v=%b r=%b want v=0 r=00", m_valid, s_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (s_ready !== 2'b01) $display("FAIL bp_ready: got %b want 01", s_ready);
    else pass_cnt++;
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic [1:0]    exp_ready [4];
    logic [AW-1:0] exp_addr  [4];
    int pulses = 0;
    int starts = 0;
    logic prev_mv = 1'b0;
    exp_ready = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_addr  = '{6'd1, 6'd2, 6'd1, 6'd2};
    apply_reset();
    s_valid = 2'b11; s_wr_rd = 2'b00; s0_addr = 6'd1; s1_addr = 6'd2; m_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && pulses < 4; cyc++) begin
      @(negedge clk);
      if (m_valid && !prev_mv) begin
        if (starts < 4) begin
          total_cnt++;
          if (m_addr !== exp_addr[starts])
            $display("FAIL cont_addr_%0d: got %0d want %0d", starts, m_addr, exp_addr[starts]);
          else pass_cnt++;
        end
        starts++;
      end
      prev_mv = m_valid;
      if (s_ready !== 2'b00) begin
        total_cnt++;
        if ({s_ready, m_valid} !== {exp_ready[pulses], 1'b0})
          $display("FAIL cont_order_%0d: got r=%b v=%b want r=%b v=0", pulses, s_ready, m_valid, exp_ready[pulses]);
        else pass_cnt++;
        pulses++;
        if (pulses == 4) s_valid = 2'b00;
      end
    end
    total_cnt++;
    if (pulses != 4 || starts != 4)
      $display("FAIL cont_count: got pulses=%0d starts=%0d want 4 and 4", pulses, starts);
    else pass_cnt++;
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    s_valid = 2'b01; s_wr_rd = 2'b01; s0_addr = 6'd7; s0_wdata = 16'h0F0F;
    @(negedge clk);
    total_cnt++;
    if (m_valid !== 1'b1) $display("FAIL rst_mid_grant: got m_valid=%b want 1", m_valid);
    else pass_cnt++;
    res = 1'b1;
    #1;
    total_cnt++;
    if (m_valid !== 1'b0) $display("FAIL rst_mid_async: got m_valid=%b want 0", m_valid);
    else pass_cnt++;
    s_valid = 2'b00;
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    res = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total_cnt++;
      if ({m_valid, s_ready} !== 3'b000) $display("FAIL rst_mid_quiet: got v=%b r=%b want v=0 r=00", m_valid, s_ready);
      else pass_cnt++;
    end
    s_valid = 2'b11; s_wr_rd = 2'b11; s1_addr = 6'd8;
    @(negedge clk);
    total_cnt++;
    if ({m_valid, m_addr} !== {1'b1, 6'd7}) $display("FAIL rst_mid_regrant: got v=%b a=%0d want v=1 a=7", m_valid, m_addr);
    else pass_cnt++;
    s_valid = 2'b01;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (s_ready !== 2'b01) $display("FAIL rst_mid_ready: got %b want 01", s_ready);
    else pass_cnt++;
    idle_inputs();
    @(negedge clk);
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int  mv_cycles = 0;
    logic seen = 1'b0;
    idle_inputs();
    s_valid = 2'b01; s_wr_rd = 2'b00; s0_addr = 6'd3;
    for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
      @(negedge clk);
      if (err === 1'b1) seen = 1'b1;
      else if (m_valid === 1'b1) mv_cycles++;
    end
    total_cnt++;
    if (!seen) $display("FAIL to_seen: got no err within 40 cycles want err pulse");
    else pass_cnt++;
    total_cnt++;
    if ({s_ready, m_valid} !== 3'b010) $display("FAIL to_strobe: got r=%b v=%b want r=01 v=0", s_ready, m_valid);
    else pass_cnt++;
    total_cnt++;
    if (mv_cycles != 16) $display("FAIL to_length: got %0d want 16", mv_cycles);
    else pass_cnt++;
    s_valid = 2'b10; s1_addr = 6'd4; m_ready = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({err, s_ready, m_valid, m_addr} !== {1'b0, 2'b00, 1'b1, 6'd4})
      $display("FAIL to_next: got e=%b r=%b v=%b a=%0d want e=0 r=00 v=1 a=4", err, s_ready, m_valid, m_addr);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (s_ready !== 2'b10) $display("FAIL to_next_ready: got %b want 10", s_ready);
    else pass_cnt++;
    idle_inputs();
    @(negedge clk);
  endtask
`else
  task automatic test_no_timeout();
    logic any_err  = 1'b0;
    logic any_drop = 1'b0;
    idle_inputs();
    s_valid = 2'b01; s_wr_rd = 2'b01; s0_addr = 6'd3; s0_wdata = 16'h5555;
    repeat (24) begin
      @(negedge clk);
      if (err !== 1'b0) any_err = 1'b1;
      if (m_valid !== 1'b1 || s_ready !== 2'b00) any_drop = 1'b1;
    end
    total_cnt++;
    if (any_err) $display("FAIL nto_err: got err pulse want none");
    else pass_cnt++;
    total_cnt++;
    if (any_drop) $display("FAIL nto_wait: got m_valid drop or s_ready want stable GRANT");
    else pass_cnt++;
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({s_ready, err} !== 3'b010) $display("FAIL nto_ready: got r=%b e=%b want r=01 e=0", s_ready, err);
    else pass_cnt++;
    idle_inputs();
    @(negedge clk);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200us want finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_contention();
    test_reset_mid();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, memory data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, max cycles waiting for m_ready (used only with MEM_ARB_TIMEOUT_EN).
REQ-004 SHALL have port clk  input  1  single clock, all logic on posedge.
REQ-005 SHALL have port res  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports s_valid[1:0]  input  2  per-requester request valid; s_wr_rd[1:0]  input  2  1=write, 0=read.
REQ-007 SHALL have ports s0_addr/s1_addr  input  ADDR_WIDTH; s0_wdata/s1_wdata  input  DATA_WIDTH.
REQ-008 SHALL have ports s_ready[1:0]  output  2  transfer-complete strobe; s_rdata  output  DATA_WIDTH  read data, shared by both requesters.
REQ-009 SHALL have ports m_valid, m_wr_rd  output  1; m_addr  output  ADDR_WIDTH; m_wdata  output  DATA_WIDTH  (to memory).
REQ-010 SHALL have ports m_ready  input  1; m_rdata  input  DATA_WIDTH  (from memory).
REQ-011 SHALL have port err  output  1  timeout error strobe (tied 0 without MEM_ARB_TIMEOUT_EN).

Function
REQ-012 SHALL implement FSM states IDLE, GRANT, DONE.
REQ-013 IDLE: if any s_valid high, SHALL pick a winner, latch its wr_rd/addr/wdata into registers and go to GRANT next cycle; else stay IDLE.
REQ-014 Arbitration SHALL be round-robin: if both valid, the requester not granted last wins; single request wins immediately; after reset requester 0 has priority.
REQ-015 GRANT: m_valid SHALL be 1 and m_wr_rd/m_addr/m_wdata SHALL show the latched values, stable until m_ready.
REQ-016 GRANT with m_ready=1: SHALL capture m_rdata (reads only), drop m_valid next cycle, go to DONE.
REQ-017 DONE: SHALL pulse s_ready[winner] for exactly one cycle, drive s_rdata with the captured data, update last-grant pointer, return to IDLE.
REQ-018 Latency: s_valid high in IDLE with m_ready already high -> s_ready 3 cycles later (IDLE->GRANT->DONE).
REQ-019 Requesters SHALL hold s_valid and payload until s_ready; the loser's request stays pending and is granted on the next IDLE.
REQ-020 s_valid dropped by the winner after latching SHALL NOT abort the transfer.
REQ-021 s_rdata SHALL hold its last value outside DONE; it is undefined for writes (no update).
REQ-022 Only one memory transfer SHALL be outstanding at any time; m_valid never high in IDLE or DONE.

Reset
REQ-023 On res high, asynchronously: state=IDLE, m_valid=0, m_wr_rd=0, m_addr=0, m_wdata=0, s_ready=0, s_rdata=0, err=0, last-grant pointer=1 (requester 0 favoured).
REQ-024 Reset mid-transfer SHALL abandon the transfer with no s_ready pulse; requesters re-present after reset.

Configuration
REQ-025 Macro MEM_ARB_TIMEOUT_EN defined: counter runs in GRANT; reaching TIMEOUT cycles without m_ready SHALL drop m_valid, pulse err and s_ready[winner] together for one cycle (s_rdata unchanged), go IDLE.
REQ-026 Macro undefined: no counter, err tied 0, GRANT waits indefinitely for m_ready.

Structure
REQ-027 Package mem_arb_pkg SHALL hold the state enum, default ADDR_WIDTH/DATA_WIDTH/TIMEOUT constants and the requester count (2).
REQ-028 Round-robin pick SHALL be sub-module mem_arb_rr (inputs request vector, last-grant; output one-hot grant).

Verification
REQ-029 Single write: s_valid=01, s_wr_rd=01, s0_addr=5, s0_wdata=16'hA5A5, m_ready=1 -> m_valid one cycle with addr 5, s_ready=01 pulse 3 cycles after request.
REQ-030 Read-back: s1 read addr 5, memory m_rdata=16'hA5A5 -> s_ready=10 pulse, s_rdata=16'hA5A5.
REQ-031 Contention: s_valid=11 held for 4 transfers after reset -> grant order 0,1,0,1; no overlapping m_valid.
REQ-032 Back-pressure: m_ready low 5 cycles in GRANT -> m_valid/m_addr/m_wdata stable 5 cycles, s_ready only after m_ready.
REQ-033 Reset mid-GRANT: res asserted -> m_valid=0 same cycle, no s_ready, state IDLE.
REQ-034 MEM_ARB_TIMEOUT_EN, TIMEOUT=16, m_ready held 0 -> err and s_ready[winner] pulse together, m_valid low, next request granted.
